openframe_gpio_cfg_ctrl: RTL and testbench

//  Parametrised successor to the openframe tie-off wrapper. Holds a per-pad

---
 rtl/openframe_gpio_pkg.sv | 23 ++
 rtl/openframe_gpio_sync.sv | 27 ++
 rtl/openframe_gpio_cfg_ctrl.sv | 114 +++++++++++
 tb/tb_openframe_gpio_cfg_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/openframe_gpio_pkg.sv
// Shared definitions for the openframe GPIO configuration controller:
// config word layout and load-FSM state encoding.
package openframe_gpio_pkg;

    localparam int CFG_W       = 10;
    localparam int CFG_OUT     = 0;
    localparam int CFG_OE      = 1;
    localparam int CFG_IE      = 2;
    localparam int CFG_SCHMITT = 3;
    localparam int CFG_SLEW    = 4;
    localparam int CFG_PU      = 5;
    localparam int CFG_PD      = 6;
    localparam int CFG_DRV0    = 7;
    localparam int CFG_DRV1    = 8;
    localparam int CFG_USER_EN = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/openframe_gpio_sync.sv
// Vector synchroniser: STAGES flops per bit, synchronous active-high reset.
module openframe_gpio_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_d;
            for (int s = 1; s < STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/openframe_gpio_cfg_ctrl.sv
// Serially loaded, atomically committed per-pad configuration for the
// openframe GPIO padframe, plus synchronised gpio_in return path.
module openframe_gpio_cfg_ctrl
    import openframe_gpio_pkg::*;
#(
    parameter int               NUM_PADS    = 44,
    parameter int               SYNC_STAGES = 2,
    parameter logic [CFG_W-1:0] DEFAULT_CFG = 10'h000,
    localparam int              TOTAL       = NUM_PADS * CFG_W,
    localparam int              CNT_W       = $clog2(TOTAL + 1)
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cfg_data_i,
    input  logic                cfg_valid_i,
    input  logic                cfg_apply_i,
    input  logic                cfg_clear_i,
    output logic                cfg_full_o,
    output logic                cfg_done_o,
    output logic                cfg_err_o,
    input  logic [NUM_PADS-1:0] user_out_i,
    input  logic [NUM_PADS-1:0] user_oe_i,
    output logic [NUM_PADS-1:0] user_in_o,
    input  logic [NUM_PADS-1:0] gpio_in,
    output logic [NUM_PADS-1:0] gpio_out,
    output logic [NUM_PADS-1:0] gpio_oe,
    output logic [NUM_PADS-1:0] gpio_ie,
    output logic [NUM_PADS-1:0] gpio_schmitt,
    output logic [NUM_PADS-1:0] gpio_slew,
    output logic [NUM_PADS-1:0] gpio_pullup,
    output logic [NUM_PADS-1:0] gpio_pulldown,
    output logic [NUM_PADS-1:0] gpio_drive0,
    output logic [NUM_PADS-1:0] gpio_drive1,
    output state_t              o_state,
    output logic [CNT_W-1:0]    o_count
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [TOTAL-1:0]   r_shadow;
    logic [TOTAL-1:0]   r_active;
    logic               r_done;
    logic               r_err;
    logic [NUM_PADS-1:0] w_sync_in;

    // Priority: reset, clear, apply, valid. A commit only happens from FULL;
    // any apply elsewhere or any bit offered while FULL is a protocol error.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_shadow <= '0;
            r_active <= {NUM_PADS{DEFAULT_CFG}};
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (cfg_clear_i) begin
                r_state <= IDLE;
                r_count <= '0;
                r_err   <= 1'b0;
            end else if (cfg_apply_i && r_state == FULL) begin
                r_active <= r_shadow;
                r_done   <= 1'b1;
                r_state  <= IDLE;
                r_count  <= '0;
                if (cfg_valid_i) r_err <= 1'b1;
            end else begin
                if (cfg_apply_i) r_err <= 1'b1;
                if (cfg_valid_i) begin
                    if (r_state == FULL) begin
                        r_err <= 1'b1;
                    end else begin
                        r_shadow <= {r_shadow[TOTAL-2:0], cfg_data_i};
                        r_count  <= r_count + 1'b1;
                        r_state  <= (r_count == CNT_W'(TOTAL - 1)) ? FULL : SHIFT;
                    end
                end
            end
        end
    end

    openframe_gpio_sync #(
        .WIDTH (NUM_PADS),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk(wb_clk_i),
        .i_rst(wb_rst_i),
        .i_d  (gpio_in),
        .o_q  (w_sync_in)
    );

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        logic [CFG_W-1:0] w_cfg;
        assign w_cfg            = r_active[p*CFG_W +: CFG_W];
        assign gpio_out[p]      = w_cfg[CFG_USER_EN] ? user_out_i[p] : w_cfg[CFG_OUT];
        assign gpio_oe[p]       = w_cfg[CFG_USER_EN] ? user_oe_i[p]  : w_cfg[CFG_OE];
        assign gpio_ie[p]       = w_cfg[CFG_IE];
        assign gpio_schmitt[p]  = w_cfg[CFG_SCHMITT];
        assign gpio_slew[p]     = w_cfg[CFG_SLEW];
        assign gpio_pullup[p]   = w_cfg[CFG_PU];
        assign gpio_pulldown[p] = w_cfg[CFG_PD];
        assign gpio_drive0[p]   = w_cfg[CFG_DRV0];
        assign gpio_drive1[p]   = w_cfg[CFG_DRV1];
        assign user_in_o[p]     = w_sync_in[p] & w_cfg[CFG_IE];
    end

    assign cfg_full_o = (r_state == FULL);
    assign cfg_done_o = r_done;
    assign cfg_err_o  = r_err;
    assign o_state    = r_state;
    assign o_count    = r_count;

endmodule

// File: tb/tb_openframe_gpio_cfg_ctrl.sv
// Directed bench for openframe_gpio_cfg_ctrl at NUM_PADS=4 (40-bit chain).
module tb_openframe_gpio_cfg_ctrl;
    import openframe_gpio_pkg::*;

    localparam int NP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_data, cfg_valid, cfg_apply, cfg_clear;
    logic          cfg_full, cfg_done, cfg_err;
    logic [NP-1:0] user_out, user_oe, user_in, gpio_in;
    logic [NP-1:0] g_out, g_oe, g_ie, g_sch, g_slew, g_pu, g_pd, g_d0, g_d1;
    state_t        dbg_state;
    logic [5:0]    dbg_count;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    openframe_gpio_cfg_ctrl #(
        .NUM_PADS(NP), .SYNC_STAGES(2), .DEFAULT_CFG(10'h000)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cfg_data_i(cfg_data), .cfg_valid_i(cfg_valid),
        .cfg_apply_i(cfg_apply), .cfg_clear_i(cfg_clear),
        .cfg_full_o(cfg_full), .cfg_done_o(cfg_done), .cfg_err_o(cfg_err),
        .user_out_i(user_out), .user_oe_i(user_oe), .user_in_o(user_in),
        .gpio_in(gpio_in),
        .gpio_out(g_out), .gpio_oe(g_oe), .gpio_ie(g_ie),
        .gpio_schmitt(g_sch), .gpio_slew(g_slew), .gpio_pullup(g_pu),
        .gpio_pulldown(g_pd), .gpio_drive0(g_d0), .gpio_drive1(g_d1),
        .o_state(dbg_state), .o_count(dbg_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends the top n bits of word, MSB first.
    task automatic shift_bits(input logic [39:0] word, input int n);
        for (int i = 39; i > 39 - n; i--) begin
            cfg_data  = word[i];
            cfg_valid = 1'b1;
            step();
        end
        cfg_valid = 1'b0;
        cfg_data  = 1'b0;
    endtask

    task automatic pulse_apply();
        cfg_apply = 1'b1;
        step();
        cfg_apply = 1'b0;
    endtask

    task automatic pulse_clear();
        cfg_clear = 1'b1;
        step();
        cfg_clear = 1'b0;
    endtask

    function automatic logic [35:0] all_gpio();
        return {g_out, g_oe, g_ie, g_sch, g_slew, g_pu, g_pd, g_d0, g_d1};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_data = 0; cfg_valid = 0; cfg_apply = 0; cfg_clear = 0;
        user_out = '0; user_oe = '0; gpio_in = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // 1: reset state
        chk("rst_gpio", 64'(all_gpio()), 64'h0);
        chk("rst_full", 64'(cfg_full), 64'h0);
        chk("rst_err", 64'(cfg_err), 64'h0);
        chk("rst_done", 64'(cfg_done), 64'h0);
        chk("rst_user_in", 64'(user_in), 64'h0);
        chk("rst_state", 64'(dbg_state), 64'(IDLE));
        chk("rst_count", 64'(dbg_count), 64'h0);

        // 2: pad0 = IE|OE
        shift_bits({10'h000, 10'h000, 10'h000, 10'h006}, 40);
        chk("t2_full", 64'(cfg_full), 64'h1);
        chk("t2_count40", 64'(dbg_count), 64'd40);
        chk("t2_gpio_pre", 64'(all_gpio()), 64'h0);
        pulse_apply();
        chk("t2_done", 64'(cfg_done), 64'h1);
        chk("t2_oe", 64'(g_oe), 64'b0001);
        chk("t2_ie", 64'(g_ie), 64'b0001);
        chk("t2_out", 64'(g_out), 64'b0000);
        chk("t2_count0", 64'(dbg_count), 64'h0);
        chk("t2_state", 64'(dbg_state), 64'(IDLE));
        chk("t2_full_off", 64'(cfg_full), 64'h0);
        step();
        chk("t2_done_once", 64'(cfg_done), 64'h0);

        // 3: early apply is an error, clear recovers, fresh load commits
        shift_bits(40'hFF_FFFF_FFFF, 20);
        chk("t3_count20", 64'(dbg_count), 64'd20);
        pulse_apply();
        chk("t3_err", 64'(cfg_err), 64'h1);
        chk("t3_no_done", 64'(cfg_done), 64'h0);
        chk("t3_gpio_keep", 64'(all_gpio()), 64'({4'b0000, 4'b0001, 4'b0001, 24'h0}));
        chk("t3_still_shift", 64'(dbg_state), 64'(SHIFT));
        pulse_clear();
        chk("t3_err_clr", 64'(cfg_err), 64'h0);
        chk("t3_clr_idle", 64'(dbg_state), 64'(IDLE));
        chk("t3_clr_count", 64'(dbg_count), 64'h0);
        // pad3=DRV1|OE|OUT, pad2=USER_EN|IE|OE, pad1=DRV0|PD|PU|SLEW|SCHMITT|OUT, pad0=IE
        shift_bits({10'h103, 10'h206, 10'h0F9, 10'h004}, 40);
        pulse_apply();
        chk("t3_done", 64'(cfg_done), 64'h1);
        chk("t3_out", 64'(g_out), 64'b1010);
        chk("t3_oe", 64'(g_oe), 64'b1000);
        chk("t3_ie", 64'(g_ie), 64'b0101);
        chk("t3_misc", 64'({g_sch, g_slew, g_pu, g_pd, g_d0, g_d1}),
            64'({4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000}));

        // 4: user override and input synchroniser
        user_out = 4'b0100; user_oe = 4'b0100;
        #1;
        chk("t4_user_out", 64'(g_out), 64'b1110);
        chk("t4_user_oe", 64'(g_oe), 64'b1100);
        user_out = 4'b1011; user_oe = 4'b1011;
        #1;
        chk("t4_user_gate_out", 64'(g_out), 64'b1010);
        chk("t4_user_gate_oe", 64'(g_oe), 64'b1000);
        gpio_in = 4'b0111;
        step();
        chk("t4_sync_lat1", 64'(user_in), 64'b0000);
        step();
        chk("t4_sync_lat2", 64'(user_in), 64'b0101);
        gpio_in = 4'b0000;
        step();
        chk("t4_sync_hold", 64'(user_in), 64'b0101);
        step();
        chk("t4_sync_fall", 64'(user_in), 64'b0000);
        user_out = '0; user_oe = '0;

        // 5: overflow bit dropped, original chain commits
        shift_bits({10'h000, 10'h000, 10'h000, 10'h018}, 40);
        cfg_data = 1'b1; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0; cfg_data = 1'b0;
        chk("t5_ovf_err", 64'(cfg_err), 64'h1);
        chk("t5_ovf_full", 64'(cfg_full), 64'h1);
        chk("t5_ovf_count", 64'(dbg_count), 64'd40);
        pulse_apply();
        chk("t5_done", 64'(cfg_done), 64'h1);
        chk("t5_gpio", 64'(all_gpio()), 64'({4'b0, 4'b0, 4'b0, 4'b0001, 4'b0001, 16'h0}));
        chk("t5_err_sticky", 64'(cfg_err), 64'h1);
        pulse_clear();
        // valid together with apply in FULL: commit, bit dropped, error
        shift_bits({10'h000, 10'h000, 10'h000, 10'h080}, 40);
        cfg_apply = 1'b1; cfg_valid = 1'b1; cfg_data = 1'b1;
        step();
        cfg_apply = 1'b0; cfg_valid = 1'b0; cfg_data = 1'b0;
        chk("t5b_done", 64'(cfg_done), 64'h1);
        chk("t5b_err", 64'(cfg_err), 64'h1);
        chk("t5b_count", 64'(dbg_count), 64'h0);
        chk("t5b_gpio", 64'(all_gpio()), 64'({28'h0, 4'b0001, 4'b0000}));
        pulse_clear();

        // 6: reset mid-load
        shift_bits(40'hFF_FFFF_FFFF, 25);
        chk("t6_count25", 64'(dbg_count), 64'd25);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_idle", 64'(dbg_state), 64'(IDLE));
        chk("t6_count0", 64'(dbg_count), 64'h0);
        chk("t6_gpio_default", 64'(all_gpio()), 64'h0);
        pulse_apply();
        chk("t6_apply_err", 64'(cfg_err), 64'h1);
        chk("t6_no_done", 64'(cfg_done), 64'h0);
        chk("t6_no_commit", 64'(all_gpio()), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
